// File: rtl/ps2_key_ctrl_if.sv
// Key event bus between the PS/2 receiver and the key decoder.
// The receiver drives an event with key_valid and holds it until key_ready.
interface ps2_key_ctrl_if;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       key_ready;

    modport master (
        output key_code,
        output key_ext,
        output key_break,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_ext,
        input  key_break,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: synchronises the pins, assembles and checks 11-bit
// frames, guards against stalled frames with a watchdog, folds E0/F0 prefixes
// into a single key event and offers it on a valid/ready bus.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYC = 5000,
    parameter int TW          = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           PS2_CLK,
    input  logic           PS2_DATA,
    ps2_key_ctrl_if.master key_if,
    output logic           frame_err,
    output logic           overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [TW-1:0] WDOG_MAX = TW'(TIMEOUT_CYC);

    // Synchroniser chain plus the previous clock sample for edge detection
    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_dat_meta_q, ps2_dat_sync_q;

    logic [1:0]    state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [10:0]   sr_q, sr_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          frame_err_q, frame_err_d;

    logic          ext_q, ext_d;
    logic          brk_q, brk_d;

    logic [7:0]    code_q, code_d;
    logic          kext_q, kext_d;
    logic          kbrk_q, kbrk_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    logic          ps2_fall;
    logic          frame_ok;
    logic          byte_vld;
    logic          evt_vld;

    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q;
    assign frame_ok = (sr_q[0] == 1'b0) && (sr_q[10] == 1'b1) && (^sr_q[9:1] == 1'b1);

    // Two-flop synchronisers; idle level of both lines is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2_clk_meta_q <= 1'b1;
            ps2_clk_sync_q <= 1'b1;
            ps2_clk_prev_q <= 1'b1;
            ps2_dat_meta_q <= 1'b1;
            ps2_dat_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q <= PS2_CLK;
            ps2_clk_sync_q <= ps2_clk_meta_q;
            ps2_clk_prev_q <= ps2_clk_sync_q;
            ps2_dat_meta_q <= PS2_DATA;
            ps2_dat_sync_q <= ps2_dat_meta_q;
        end
    end

    // Frame FSM: shift bits in on each falling PS/2 clock, watchdog the gaps, check the frame
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        sr_d        = sr_q;
        wdog_d      = wdog_q;
        frame_err_d = 1'b0;
        byte_vld    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ps2_fall) begin
                    state_d  = ST_RECV;
                    bitcnt_d = 4'd1;
                    sr_d     = {ps2_dat_sync_q, sr_q[10:1]};
                    wdog_d   = '0;
                end
            end
            ST_RECV: begin
                if (ps2_fall) begin
                    sr_d     = {ps2_dat_sync_q, sr_q[10:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    wdog_d   = '0;
                    if (bitcnt_q == 4'd10) begin
                        state_d = ST_CHECK;
                    end
                end else if (wdog_q == WDOG_MAX) begin
                    // Stalled frame: drop what we have and report it
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_ok) begin
                    byte_vld = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prefix tracking: E0/F0 only set flags, any other byte becomes an event
    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        evt_vld = 1'b0;
        if (state_q == ST_CHECK && !frame_ok) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld) begin
            if (sr_q[8:1] == 8'hE0) begin
                ext_d = 1'b1;
            end else if (sr_q[8:1] == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                evt_vld = 1'b1;
                ext_d   = 1'b0;
                brk_d   = 1'b0;
            end
        end
    end

    // Event holding register: load when free or being consumed, else flag overrun
    always_comb begin
        code_d    = code_q;
        kext_d    = kext_q;
        kbrk_d    = kbrk_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && key_if.key_ready) begin
            valid_d = 1'b0;
        end
        if (evt_vld) begin
            if (valid_q && !key_if.key_ready) begin
                overrun_d = 1'b1;
            end else begin
                code_d  = sr_q[8:1];
                kext_d  = ext_q;
                kbrk_d  = brk_q;
                valid_d = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            sr_q        <= '0;
            wdog_q      <= '0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            code_q      <= '0;
            kext_q      <= 1'b0;
            kbrk_q      <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            sr_q        <= sr_d;
            wdog_q      <= wdog_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            code_q      <= code_d;
            kext_q      <= kext_d;
            kbrk_q      <= kbrk_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign key_if.key_code  = code_q;
    assign key_if.key_ext   = kext_q;
    assign key_if.key_break = kbrk_q;
    assign key_if.key_valid = valid_q;
    assign frame_err        = frame_err_q;
    assign overrun          = overrun_q;

endmodule
